// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - true dual-port synchronous RAM with clear sweep and collision flag; DPRAM_OUT_REG_EN adds an output register stage
module dual_port_ram_param #(
    parameter int                   DATA_SIZE  = 8,
    parameter int                   DEPTH      = 16,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0,
    parameter int                   ADDR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_a,
    input  logic                 cs_b,
    input  logic                 wr_en_a,
    input  logic                 wr_en_b,
    input  logic                 rd_en_a,
    input  logic                 rd_en_b,
    input  logic [ADDR_W-1:0]    addr_a,
    input  logic [ADDR_W-1:0]    addr_b,
    input  logic [DATA_SIZE-1:0] wdata_a,
    input  logic [DATA_SIZE-1:0] wdata_b,
    output logic [DATA_SIZE-1:0] rdata_a,
    output logic [DATA_SIZE-1:0] rdata_b,
    output logic                 rvalid_a,
    output logic                 rvalid_b,
    output logic                 busy,
    output logic                 collision
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [DATA_SIZE-1:0]   mem [DEPTH];
    logic [DATA_SIZE-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic                   rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic                   collision_q, collision_d;
    logic                   clr_we, we_a, we_b, re_a, re_b;
    logic                   in_a, in_b;

    // Addresses beyond DEPTH exist only when DEPTH is not a power of two
    assign in_a = ({1'b0, addr_a} < DEPTH_EXT);
    assign in_b = ({1'b0, addr_b} < DEPTH_EXT);

    // Sweep sequencing, request decode and read-first data capture
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clr_we      = 1'b0;
        we_a        = 1'b0;
        we_b        = 1'b0;
        re_a        = 1'b0;
        re_b        = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        rvalid_a_d  = 1'b0;
        rvalid_b_d  = 1'b0;
        collision_d = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            READY: begin
                we_a = cs_a & wr_en_a;
                we_b = cs_b & wr_en_b;
                re_a = cs_a & ~wr_en_a & rd_en_a;
                re_b = cs_b & ~wr_en_b & rd_en_b;
                if (re_a) begin
                    rvalid_a_d = 1'b1;
                    rdata_a_d  = in_a ? mem[addr_a] : INIT_VALUE;
                end
                if (re_b) begin
                    rvalid_b_d = 1'b1;
                    rdata_b_d  = in_b ? mem[addr_b] : INIT_VALUE;
                end
                collision_d = we_a & we_b & (addr_a == addr_b);
            end
            default: state_d = CLEAR;
        endcase
    end

    // Control and first read stage; memory array itself is never reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
            collision_q <= collision_d;
        end
    end

    // Storage writes: sweep, else port writes with A taking a shared address
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= INIT_VALUE;
        end else begin
            if (we_b && in_b && !(we_a && (addr_a == addr_b))) begin
                mem[addr_b] <= wdata_b;
            end
            if (we_a && in_a) begin
                mem[addr_a] <= wdata_a;
            end
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_SIZE-1:0] rdata_a_o_q, rdata_a_o_d, rdata_b_o_q, rdata_b_o_d;
    logic                 rvalid_a_o_q, rvalid_a_o_d, rvalid_b_o_q, rvalid_b_o_d;

    // Output stage copies the first stage unconditionally, keeping data and strobe aligned
    always_comb begin
        rdata_a_o_d  = rdata_a_q;
        rdata_b_o_d  = rdata_b_q;
        rvalid_a_o_d = rvalid_a_q;
        rvalid_b_o_d = rvalid_b_q;
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_o_q  <= '0;
            rdata_b_o_q  <= '0;
            rvalid_a_o_q <= 1'b0;
            rvalid_b_o_q <= 1'b0;
        end else begin
            rdata_a_o_q  <= rdata_a_o_d;
            rdata_b_o_q  <= rdata_b_o_d;
            rvalid_a_o_q <= rvalid_a_o_d;
            rvalid_b_o_q <= rvalid_b_o_d;
        end
    end

    assign rdata_a  = rdata_a_o_q;
    assign rdata_b  = rdata_b_o_q;
    assign rvalid_a = rvalid_a_o_q;
    assign rvalid_b = rvalid_b_o_q;
`else
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
`endif

    assign busy      = (state_q == CLEAR);
    assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb/tb_dual_port_ram_param.sv - randomized reference-model bench for dual_port_ram_param
module tb_dual_port_ram_param;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk, rst_n;
    logic       cs_a, cs_b, wr_en_a, wr_en_b, rd_en_a, rd_en_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic       rvalid_a, rvalid_b, busy, collision;

    logic       s_cs_a, s_cs_b, s_wr_en_a, s_wr_en_b, s_rd_en_a, s_rd_en_b;
    logic [3:0] s_addr_a, s_addr_b;
    logic [7:0] s_wdata_a, s_wdata_b, s_rdata_a, s_rdata_b;
    logic       s_rvalid_a, s_rvalid_b, s_busy, s_collision;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [16];
    logic        m_va, m_vb, exp_va, exp_vb, exp_col;
    logic [7:0]  m_da, m_db, exp_da, exp_db;
    logic [18:0] obs;

    assign obs = {rvalid_a, rdata_a, rvalid_b, rdata_b, collision};

    dual_port_ram_param #(.DATA_SIZE(8), .DEPTH(16), .INIT_VALUE(8'hA5)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .cs_a(cs_a), .cs_b(cs_b), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .busy(busy), .collision(collision)
    );

    dual_port_ram_param #(.DATA_SIZE(8), .DEPTH(12), .INIT_VALUE(8'h5A)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .cs_a(s_cs_a), .cs_b(s_cs_b), .wr_en_a(s_wr_en_a), .wr_en_b(s_wr_en_b),
        .rd_en_a(s_rd_en_a), .rd_en_b(s_rd_en_b), .addr_a(s_addr_a), .addr_b(s_addr_b),
        .wdata_a(s_wdata_a), .wdata_b(s_wdata_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b),
        .rvalid_a(s_rvalid_a), .rvalid_b(s_rvalid_b), .busy(s_busy), .collision(s_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        cs_a = 0; cs_b = 0; wr_en_a = 0; wr_en_b = 0; rd_en_a = 0; rd_en_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        s_cs_a = 0; s_cs_b = 0; s_wr_en_a = 0; s_wr_en_b = 0; s_rd_en_a = 0; s_rd_en_b = 0;
        s_addr_a = 0; s_addr_b = 0; s_wdata_a = 0; s_wdata_b = 0;
    endtask

    // Memory as left by a completed sweep; read outputs as left by reset
    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'hA5;
        m_va = 0; m_vb = 0; m_da = 0; m_db = 0;
        exp_va = 0; exp_vb = 0; exp_da = 0; exp_db = 0; exp_col = 0;
    endtask

    // One clock on the depth-16 RAM: read-first, write beats read on a port, A wins a shared write
    task automatic cycle();
        logic ra, rb, wa, wb;
        logic [7:0] da, db;
        @(posedge clk);
        wa = cs_a && wr_en_a;
        wb = cs_b && wr_en_b;
        ra = cs_a && !wr_en_a && rd_en_a;
        rb = cs_b && !wr_en_b && rd_en_b;
        da = ref_mem[addr_a];
        db = ref_mem[addr_b];
        exp_col = wa && wb && (addr_a == addr_b);
        if (wb) ref_mem[addr_b] = wdata_b;
        if (wa) ref_mem[addr_a] = wdata_a;
        if (LAT == 2) begin
            exp_va = m_va; exp_da = m_da; exp_vb = m_vb; exp_db = m_db;
        end
        m_va = ra; m_vb = rb;
        if (ra) m_da = da;
        if (rb) m_db = db;
        if (LAT == 1) begin
            exp_va = m_va; exp_da = m_da; exp_vb = m_vb; exp_db = m_db;
        end
        #1;
    endtask

    // Release reset and time the sweep on both RAMs; no port activity may leak out while busy
    task automatic wait_sweep(input string tag);
        int n, sn;
        n = 0; sn = 0;
        @(negedge clk);
        rst_n = 1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!s_busy && sn == 0) sn = n;
            checks++;
            if (rvalid_a || rvalid_b || collision) begin
                errors++;
                $display("FAIL %s_quiet edge=%0d got rva=%b rvb=%b col=%b exp 0 0 0", tag, n, rvalid_a, rvalid_b, collision);
            end
            if (!busy) break;
        end
        idle();
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL %s_busy16 got %0d cycles exp 16", tag, n);
        end
        checks++;
        if (sn !== 12) begin
            errors++;
            $display("FAIL %s_busy12 got %0d cycles exp 12", tag, sn);
        end
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdata_a, rvalid_a, rdata_b, rvalid_b, collision, busy} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16 got %h exp %h", {rdata_a, rvalid_a, rdata_b, rvalid_b, collision, busy}, {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        checks++;
        if ({s_rdata_a, s_rvalid_a, s_collision, s_busy} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset12 got %h exp %h", {s_rdata_a, s_rvalid_a, s_collision, s_busy}, {8'h00, 1'b0, 1'b0, 1'b1});
        end
        wait_sweep("sweep");
    endtask

    task automatic test_read_all();
        for (int i = 0; i < 16 + LAT; i++) begin
            idle();
            if (i < 16) begin
                cs_a = 1; rd_en_a = 1; addr_a = 4'(i);
            end
            cycle();
            checks++;
            if (obs !== {exp_va, exp_da, exp_vb, exp_db, exp_col}) begin
                errors++;
                $display("FAIL read_all step=%0d got %h exp %h", i, obs, {exp_va, exp_da, exp_vb, exp_db, exp_col});
            end
        end
        checks++;
        if (rdata_a !== 8'hA5) begin
            errors++;
            $display("FAIL read_all_hold got %h exp a5", rdata_a);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 2 + LAT; i++) begin
            idle();
            if (i == 0) begin cs_a = 1; wr_en_a = 1; addr_a = 3; wdata_a = 8'h3C; end
            if (i == 1) begin cs_b = 1; rd_en_b = 1; addr_b = 3; end
            cycle();
            checks++;
            if (obs !== {exp_va, exp_da, exp_vb, exp_db, exp_col}) begin
                errors++;
                $display("FAIL write_read step=%0d got %h exp %h", i, obs, {exp_va, exp_da, exp_vb, exp_db, exp_col});
            end
            if (i == LAT) begin
                checks++;
                if ({rvalid_b, rdata_b} !== {1'b1, 8'h3C}) begin
                    errors++;
                    $display("FAIL write_read_latency got %h exp 13c", {rvalid_b, rdata_b});
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 3 + LAT; i++) begin
            idle();
            if (i == 0) begin
                cs_a = 1; wr_en_a = 1; addr_a = 5; wdata_a = 8'h11;
                cs_b = 1; wr_en_b = 1; addr_b = 5; wdata_b = 8'h22;
            end
            if (i == 2) begin cs_a = 1; rd_en_a = 1; addr_a = 5; end
            cycle();
            checks++;
            if (obs !== {exp_va, exp_da, exp_vb, exp_db, exp_col}) begin
                errors++;
                $display("FAIL collision step=%0d got %h exp %h", i, obs, {exp_va, exp_da, exp_vb, exp_db, exp_col});
            end
            if (i == 0) begin
                checks++;
                if (collision !== 1'b1) begin
                    errors++;
                    $display("FAIL collision_pulse got %b exp 1", collision);
                end
            end
        end
        checks++;
        if (rdata_a !== 8'h11) begin
            errors++;
            $display("FAIL collision_winner got %h exp 11", rdata_a);
        end
    endtask

    task automatic test_read_first();
        for (int i = 0; i < 4 + LAT; i++) begin
            idle();
            if (i == 0) begin cs_a = 1; wr_en_a = 1; addr_a = 7; wdata_a = 8'h40; end
            if (i == 1) begin
                cs_a = 1; wr_en_a = 1; addr_a = 7; wdata_a = 8'h99;
                cs_b = 1; rd_en_b = 1; addr_b = 7;
            end
            if (i == 3) begin cs_b = 1; rd_en_b = 1; addr_b = 7; end
            cycle();
            checks++;
            if (obs !== {exp_va, exp_da, exp_vb, exp_db, exp_col}) begin
                errors++;
                $display("FAIL read_first step=%0d got %h exp %h", i, obs, {exp_va, exp_da, exp_vb, exp_db, exp_col});
            end
            if (i == 1 + LAT - 1) begin
                checks++;
                if (rdata_b !== 8'h40) begin
                    errors++;
                    $display("FAIL read_first_old got %h exp 40", rdata_b);
                end
            end
        end
        checks++;
        if (rdata_b !== 8'h99) begin
            errors++;
            $display("FAIL read_first_new got %h exp 99", rdata_b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            idle();
            cs_a = 1'($urandom); wr_en_a = 1'($urandom); rd_en_a = 1'($urandom);
            cs_b = 1'($urandom); wr_en_b = 1'($urandom); rd_en_b = 1'($urandom);
            addr_a = 4'($urandom);
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
            wdata_a = 8'($urandom); wdata_b = 8'($urandom);
            cycle();
            checks++;
            if (obs !== {exp_va, exp_da, exp_vb, exp_db, exp_col}) begin
                errors++;
                $display("FAIL random step=%0d got %h exp %h", i, obs, {exp_va, exp_da, exp_vb, exp_db, exp_col});
            end
        end
        idle();
        repeat (LAT) cycle();
    endtask

    task automatic test_reset_mid_sweep();
        idle();
        cs_a = 1; wr_en_a = 1; addr_a = 9; wdata_a = 8'h6E;
        cycle();
        idle();
        cs_a = 1; rd_en_a = 1; addr_a = 9;
        cycle();
        idle();
        for (int k = 1; k < LAT; k++) cycle();
        checks++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'h6E}) begin
            errors++;
            $display("FAIL pre_reset_read got %h exp 16e", {rvalid_a, rdata_a});
        end
        rst_n = 0;
        #1;
        checks++;
        if ({rvalid_a, rdata_a, busy} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_read got %h exp 001", {rvalid_a, rdata_a, busy});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            cs_a = 1; wr_en_a = 1; addr_a = 4'($urandom); wdata_a = 8'hFF;
            cs_b = 1; rd_en_b = 1; addr_b = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({busy, rvalid_a, rvalid_b, collision} !== 4'b1000) begin
                errors++;
                $display("FAIL busy_drop edge=%0d got %b exp 1000", i, {busy, rvalid_a, rvalid_b, collision});
            end
        end
        rst_n = 0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_sweep got busy=%b exp 1", busy);
        end
        wait_sweep("restart");
        test_read_all();
    endtask

    task automatic test_depth12();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        idle();
        s_cs_a = 1; s_wr_en_a = 1; s_addr_a = 13; s_wdata_a = 8'h77;
        @(posedge clk); #1;
        s_wr_en_a = 0; s_rd_en_a = 1; s_addr_a = 13;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        checks++;
        if ({s_rvalid_a, s_rdata_a} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL d12_oob_read got %h exp 15a", {s_rvalid_a, s_rdata_a});
        end
        @(posedge clk); #1;
        checks++;
        if (s_rvalid_a !== 1'b0) begin
            errors++;
            $display("FAIL d12_rvalid_pulse got %b exp 0", s_rvalid_a);
        end
        s_cs_a = 1; s_wr_en_a = 1; s_addr_a = 11; s_wdata_a = v;
        @(posedge clk); #1;
        s_wr_en_a = 0; s_rd_en_a = 1; s_addr_a = 11;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        checks++;
        if ({s_rvalid_a, s_rdata_a} !== {1'b1, v}) begin
            errors++;
            $display("FAIL d12_addr11 got %h exp %h", {s_rvalid_a, s_rdata_a}, {1'b1, v});
        end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_write_read();
        test_collision();
        test_read_first();
        test_random();
        test_reset_mid_sweep();
        test_depth12();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
# dual_port_ram_param

Parametrised true dual-port synchronous RAM with two independent ports (A, B), separate write/read data buses, registered reads with a valid strobe, a post-reset clear sweep and write-collision detection. It is the general-purpose on-chip memory for the Memories library, replacing fixed 16x8 tristate-bus RAMs in FIFOs, line buffers and register files.

## Interface
- DATA_SIZE, 8, word width in bits
- DEPTH, 16, number of words (any value ≥ 2; need not be a power of two)
- INIT_VALUE, 0, word written to every location by the clear sweep
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cs_a / cs_b  in  1  port chip select
- wr_en_a / wr_en_b  in  1  write request (qualified by cs)
- rd_en_a / rd_en_b  in  1  read request (qualified by cs)
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  DATA_SIZE  write data
- rdata_a / rdata_b  out  DATA_SIZE  read data
- rvalid_a / rvalid_b  out  1  rdata holds a new read result this cycle
- busy  out  1  clear sweep in progress, all requests ignored
- collision  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- FSM states: CLEAR, READY. rst_n low → CLEAR, sweep pointer = 0.
- CLEAR: each cycle writes INIT_VALUE to mem[ptr], ptr++. At ptr = DEPTH-1 write, next state READY. busy = 1 throughout CLEAR; port requests dropped, no rvalid, no collision.
- READY: per port, cs & wr_en → write; else cs & rd_en → read. Write wins over read on the same port in the same cycle (no rvalid).
- Address ≥ DEPTH (non-power-of-two DEPTH): write discarded, read returns INIT_VALUE with rvalid.
- Both ports write the same address in the same cycle: port A data stored, B dropped, collision = 1 next cycle.
- Different-address simultaneous writes both complete.
- Port reads an address the other port writes in the same cycle: read-first, returns old contents.
- Both ports read the same address: both get the same data.

## Timing
- Reset values: rdata_a/b = 0, rvalid_a/b = 0, collision = 0, busy = 1.
- Clear sweep: exactly DEPTH cycles after first rising edge with rst_n high; busy falls after the edge completing the last write; first accepted request on the following edge.
- Write: mem updated on the request edge; readable by either port on the next edge.
- Read latency (macro absent): 1 cycle. Request at edge N → rdata/rvalid valid after edge N+1 for one cycle; rdata holds its value until the next read; rvalid is a one-cycle pulse per read.
- Back-to-back reads every cycle sustain full throughput.
- rst_n asserted mid-sweep or mid-read: outputs go to reset values immediately; sweep restarts from 0. Memory contents are not asynchronously cleared, only by the sweep.

## Configuration
- DPRAM_OUT_REG_EN defined: extra output register per port; read latency 2 cycles (rdata and rvalid delayed together one stage, both reset to 0); collision pulse timing unchanged.
- Undefined: latency 1 as above.

## Test plan
- Reset, DEPTH=16, INIT_VALUE=8'hA5: busy high 16 cycles; then read all 16 addresses on A → every rdata_a = A5, rvalid_a per read.
- Write A addr 3 = 8'h3C, next cycle read B addr 3 → rdata_b = 3C one cycle after request (two with DPRAM_OUT_REG_EN).
- Same cycle write A addr 5 = 8'h11, B addr 5 = 8'h22 → collision pulse next cycle; later read → 8'h11.
- Location 7 holds 8'h40; A writes 7 = 8'h99 while B reads 7 same cycle → rdata_b = 40; subsequent read → 99.
- Assert rst_n low at sweep cycle 8, release → busy high a full 16 cycles again; requests during busy produce no rvalid, memory unchanged.
- DEPTH=12: write addr 13 ignored, read addr 13 → INIT_VALUE with rvalid; write/read addr 11 works.
